// File: rtl/bk_add_operand_sequencer.sv
// Operand sequencer for the 12-bit Brent-Kung adder: buffers operand pairs,
// drives the interleaved adder bus from a register, and captures the sum.
module bk_add_operand_sequencer #(
  parameter int WIDTH      = 12,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [2*WIDTH-1:0]   add_in,
  input  logic [WIDTH:0]       add_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH:0]       res_sum,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       SETTLE_INIT = 3'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] in_bus;
  logic [2:0]         settle_cnt;
  logic               push, pop, capture, fifo_empty;

  // Pairs are interleaved on entry so the FIFO head is already in adder bus order.
  always_comb begin
    in_bus = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_bus[2*i]   = in_a[i];
      in_bus[2*i+1] = in_b[i];
    end
  end

  assign in_ready   = (count != FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (settle_cnt == 3'd0) begin
          capture    = 1'b1;
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETTLE_ST;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // add_in only changes on a pop, so the adder sees a stable bus until capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_in     <= '0;
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
    end else begin
      if (pop) begin
        add_in     <= fifo_mem[rd_ptr];
        settle_cnt <= SETTLE_INIT;
      end else if (state == SETTLE_ST && settle_cnt != 3'd0) begin
        settle_cnt <= settle_cnt - 3'd1;
      end
      if (capture) begin
        res_sum   <= add_out;
        res_valid <= 1'b1;
      end else if (state == RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
